// File: rtl/regfile_pkg.sv
// Shared types and constants for the HI/LO register file: hilo_op encodings,
// sequencer states and the default stack-pointer preload.
package regfile_pkg;

    typedef enum logic [1:0] {
        HILO_NONE = 2'b00,
        HILO_LO   = 2'b01,
        HILO_HI   = 2'b10,
        HILO_BOTH = 2'b11
    } hilo_op_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_SP_INDEX = 29;
    localparam logic [31:0] DEFAULT_SP_INIT  = 32'h0000_0400;

endpackage

// File: rtl/regfile_hilo_mp_if.sv
// Bus bundle between the datapath (master) and the register file (slave):
// read ports, GPR write port, HI/LO write path, debug peek and init status.
interface regfile_hilo_mp_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic [1:0]          hilo_op;
    logic [XLEN-1:0]     lo_wdata;
    logic [XLEN-1:0]     hi_wdata;
    logic [XLEN-1:0]     hi;
    logic [XLEN-1:0]     lo;
    logic [AW-1:0]       peek_addr;
    logic [XLEN-1:0]     peek_data;
    logic                init_done;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, hilo_op, lo_wdata, hi_wdata, peek_addr,
        input  rd_data, hi, lo, peek_data, init_done
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, hilo_op, lo_wdata, hi_wdata, peek_addr,
        output rd_data, hi, lo, peek_data, init_done
    );

endinterface

// File: rtl/regfile_clear_seq.sv
// CLEAR/READY sequencer: walks every GPR once after reset, preloading the
// stack-pointer register, then parks in READY until the next reset.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREGS    = 32,
    parameter int unsigned     SP_INDEX = DEFAULT_SP_INDEX,
    parameter logic [XLEN-1:0] SP_INIT  = DEFAULT_SP_INIT
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     clr_we_o,
    output logic [$clog2(NREGS)-1:0] clr_addr_o,
    output logic [XLEN-1:0]          clr_data_o,
    output logic                     ready_o
);
    localparam int unsigned   AW       = $clog2(NREGS);
    localparam logic [AW-1:0] SpAddr   = AW'(SP_INDEX);
    localparam logic [AW-1:0] LastAddr = AW'(NREGS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_o = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                // The array must stay untouched on the reset cycle itself.
                clr_we_o = ~reset;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign clr_addr_o = cnt_q;
    assign clr_data_o = (cnt_q == SpAddr) ? SP_INIT : '0;
    assign ready_o    = (state_q == ST_READY);

endmodule

// File: rtl/regfile_hilo_mp.sv
// Multi-port GPR file with independent HI/LO, clear sequencer and debug peek.
// Define REGFILE_BYPASS_EN for write-first forwarding on read and peek ports.
module regfile_hilo_mp
    import regfile_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREGS    = 32,
    parameter int unsigned     NRD      = 2,
    parameter int unsigned     SP_INDEX = DEFAULT_SP_INDEX,
    parameter logic [XLEN-1:0] SP_INIT  = DEFAULT_SP_INIT
) (
    input logic              clk,
    input logic              reset,
    regfile_hilo_mp_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic [XLEN-1:0] clr_data;
    logic            ready;

    regfile_clear_seq #(
        .XLEN    (XLEN),
        .NREGS   (NREGS),
        .SP_INDEX(SP_INDEX),
        .SP_INIT (SP_INIT)
    ) u_clear_seq (
        .clk       (clk),
        .reset     (reset),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr),
        .clr_data_o(clr_data),
        .ready_o   (ready)
    );

    logic [XLEN-1:0] mem_q [NREGS];
    logic            func_we;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    // clr_we and func_we are mutually exclusive: one needs CLEAR, the other READY.
    assign func_we   = ready & ~reset & bus.wr_en & (bus.wr_addr != '0);
    assign mem_we    = clr_we | func_we;
    assign mem_waddr = clr_we ? clr_addr : bus.wr_addr;
    assign mem_wdata = clr_we ? clr_data : bus.wr_data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
    logic [XLEN-1:0]     peek_q, peek_d;

    always_comb begin
        rd_data_d = '0;
        peek_d    = '0;
        for (int i = 0; i < NRD; i++) begin
            if (bus.rd_addr[i*AW +: AW] != '0) begin
                rd_data_d[i*XLEN +: XLEN] = mem_q[bus.rd_addr[i*AW +: AW]];
            end
`ifdef REGFILE_BYPASS_EN
            if (func_we && (bus.wr_addr == bus.rd_addr[i*AW +: AW])) begin
                rd_data_d[i*XLEN +: XLEN] = bus.wr_data;
            end
`endif
        end
        if (bus.peek_addr != '0) begin
            peek_d = mem_q[bus.peek_addr];
        end
`ifdef REGFILE_BYPASS_EN
        if (func_we && (bus.wr_addr == bus.peek_addr)) begin
            peek_d = bus.wr_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset || !ready) begin
            rd_data_q <= '0;
            peek_q    <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            peek_q    <= peek_d;
        end
    end

    logic            hi_we, lo_we;
    logic [XLEN-1:0] hi_q, lo_q;

    always_comb begin
        hi_we = 1'b0;
        lo_we = 1'b0;
        unique case (bus.hilo_op)
            HILO_LO:   lo_we = 1'b1;
            HILO_HI:   hi_we = 1'b1;
            HILO_BOTH: begin
                hi_we = 1'b1;
                lo_we = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (ready) begin
            if (hi_we) hi_q <= bus.hi_wdata;
            if (lo_we) lo_q <= bus.lo_wdata;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.peek_data = peek_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.init_done = ready;

endmodule
